// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial BCD adder.
package bcd_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned SUM_W    = DIGIT_W + 1;
    localparam int unsigned BCD_MAX  = 9;
    localparam int unsigned BCD_CORR = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder with decimal correction and invalid-digit flag.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] da,
    input  logic [DIGIT_W-1:0] db,
    input  logic               c,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry,
    output logic               invalid
);

    logic [SUM_W-1:0] w_t;

    // Invalid digits go through the same correction path; no saturation.
    always_comb begin
        w_t     = SUM_W'(da) + SUM_W'(db) + SUM_W'(c);
        digit   = w_t[DIGIT_W-1:0];
        carry   = 1'b0;
        invalid = (da > DIGIT_W'(BCD_MAX)) || (db > DIGIT_W'(BCD_MAX));
        if (w_t > SUM_W'(BCD_MAX)) begin
            digit = w_t[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared digit cell, LSD first, start/done handshake.
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      cin,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] s,
    output logic                      cout,
    output logic                      err
);

    localparam int unsigned W     = DIGIT_W * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_s;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic [DIGIT_W-1:0] w_digit;
    logic               w_carry;
    logic               w_invalid;

    bcd_digit_add u_digit (
        .da      (r_a[DIGIT_W*r_idx +: DIGIT_W]),
        .db      (r_b[DIGIT_W*r_idx +: DIGIT_W]),
        .c       (r_carry),
        .digit   (w_digit),
        .carry   (w_carry),
        .invalid (w_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_RUN;
                end
            end
            ST_RUN:  if (r_idx == LAST_IDX) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Status flags registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_next == ST_IDLE);
            r_busy  <= (w_next == ST_RUN);
            r_done  <= (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_s     <= '0;
            r_idx   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_s[DIGIT_W*r_idx +: DIGIT_W] <= w_digit;
            r_carry <= w_carry;
            r_err   <= r_err | w_invalid;
            if (r_idx == LAST_IDX) begin
                r_cout <= w_carry;
                r_idx  <= '0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign s     = r_s;
    assign cout  = r_cout;
    assign err   = r_err;

endmodule
